rom_fetch_unit: RTL and testbench

Instruction-fetch front end between the riscv_32i core and the instruction ROM. Accepts a word-address fetch request from the core and runs the ROM chip-enable/read handshake. Returns the instruction word with a one-cycle done pulse, which the core consumes as ROM_DONE/iROM_DATA. Also handles branch flushes and ROM timeouts. If the ROM times out, it substitutes a NOP so the core never hangs.

---
 rtl/rom_fetch_unit.sv | 185 ++++++++++++++++++
 tb/tb_rom_fetch_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/rom_fetch_unit.sv
// Instruction-fetch front end: runs the ROM CE/RD read handshake for core fetches,
// returns the word with a one-cycle oDONE pulse, and substitutes NOP_INSTR on a timeout.
// Latency is 2 cycles minimum. The ROM stalls via iROM_VALID, bounded by TIMEOUT, and iFLUSH abandons a fetch.
//
// Ports:
//   iCLK, iRST_N           clock (rising edge), asynchronous active-low reset
//   iREQ, iADDR, iFLUSH    core fetch request (level, sampled in IDLE), word address, abandon
//   oBUSY, oDONE, oINSTR   fetch in progress, completion pulse, fetched word (held)
//   oERR                   sticky timeout flag, cleared only by reset
//   oROM_CE, oROM_RD,      ROM chip enable / read strobe / word address
//   oROM_ADDR
//   iROM_DATA, iROM_VALID  ROM read data and its valid qualifier
//
// Optional build macro FETCH_HIT_EN adds a one-entry line buffer. When the last
// ROM-sourced word is requested again, it is returned without a ROM access.
module rom_fetch_unit #(
    parameter int          ADDR_W    = 8,
    parameter int          DATA_W    = 32,
    parameter int          TIMEOUT   = 16,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              iREQ,
    input  logic [ADDR_W-1:0] iADDR,
    input  logic              iFLUSH,
    output logic              oBUSY,
    output logic              oDONE,
    output logic [DATA_W-1:0] oINSTR,
    output logic              oERR,
    output logic              oROM_CE,
    output logic              oROM_RD,
    output logic [ADDR_W-1:0] oROM_ADDR,
    input  logic [DATA_W-1:0] iROM_DATA,
    input  logic              iROM_VALID
);

    // The counter only needs to reach TIMEOUT-1.
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BUSRD = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic              busy_q, busy_d;
    logic              ce_q, ce_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

`ifdef FETCH_HIT_EN
    logic              buf_vld_q, buf_vld_d;
    logic [ADDR_W-1:0] buf_tag_q, buf_tag_d;
    logic [DATA_W-1:0] buf_dat_q, buf_dat_d;
    logic              hit;

    assign hit = buf_vld_q && (buf_tag_q == iADDR);
`endif

    always_comb begin
        state_d = state_q;
        ce_d    = ce_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        done_d  = 1'b0;
        err_d   = err_q;
        cnt_d   = cnt_q;
`ifdef FETCH_HIT_EN
        buf_vld_d = buf_vld_q;
        buf_tag_d = buf_tag_q;
        buf_dat_d = buf_dat_q;
`endif

        case (state_q)
            IDLE: begin
                // A flush overrides the request. iROM_VALID is ignored while idle.
                if (iREQ && !iFLUSH) begin
`ifdef FETCH_HIT_EN
                    if (hit) begin
                        instr_d = buf_dat_q;
                        done_d  = 1'b1;
                    end else begin
                        state_d = BUSRD;
                        ce_d    = 1'b1;
                        addr_d  = iADDR;
                        cnt_d   = '0;
                    end
`else
                    state_d = BUSRD;
                    ce_d    = 1'b1;
                    addr_d  = iADDR;
                    cnt_d   = '0;
`endif
                end
            end

            BUSRD: begin
                if (iFLUSH) begin
                    // The branch redirect wins, even over data arriving this edge.
                    state_d = IDLE;
                    ce_d    = 1'b0;
                end else if (iROM_VALID) begin
                    state_d = IDLE;
                    ce_d    = 1'b0;
                    instr_d = iROM_DATA;
                    done_d  = 1'b1;
`ifdef FETCH_HIT_EN
                    buf_vld_d = 1'b1;
                    buf_tag_d = addr_q;
                    buf_dat_d = iROM_DATA;
`endif
                end else if (cnt_q == CNT_LAST) begin
                    // The ROM is unresponsive. Feed the core a NOP so it keeps running.
                    state_d = IDLE;
                    ce_d    = 1'b0;
                    instr_d = DATA_W'(NOP_INSTR);
                    done_d  = 1'b1;
                    err_d   = 1'b1;
`ifdef FETCH_HIT_EN
                    buf_vld_d = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                ce_d    = 1'b0;
            end
        endcase

        busy_d = (state_d == BUSRD);
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            ce_q    <= 1'b0;
            addr_q  <= '0;
            instr_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            ce_q    <= ce_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef FETCH_HIT_EN
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            buf_vld_q <= 1'b0;
            buf_tag_q <= '0;
            buf_dat_q <= '0;
        end else begin
            buf_vld_q <= buf_vld_d;
            buf_tag_q <= buf_tag_d;
            buf_dat_q <= buf_dat_d;
        end
    end
`endif

    assign oBUSY     = busy_q;
    assign oDONE     = done_q;
    assign oINSTR    = instr_q;
    assign oERR      = err_q;
    assign oROM_CE   = ce_q;
    assign oROM_RD   = ce_q;
    assign oROM_ADDR = addr_q;

endmodule

// File: tb/tb_rom_fetch_unit.sv
module tb_rom_fetch_unit;

    logic        iCLK = 1'b0;
    logic        iRST_N = 1'b0;
    logic        iREQ = 1'b0;
    logic [7:0]  iADDR = 8'h00;
    logic        iFLUSH = 1'b0;
    logic        oBUSY;
    logic        oDONE;
    logic [31:0] oINSTR;
    logic        oERR;
    logic        oROM_CE;
    logic        oROM_RD;
    logic [7:0]  oROM_ADDR;
    logic [31:0] iROM_DATA = 32'h0;
    logic        iROM_VALID = 1'b0;

    int checks = 0;
    int fails  = 0;

    rom_fetch_unit #(
        .ADDR_W(8), .DATA_W(32), .TIMEOUT(16), .NOP_INSTR(32'h00000013)
    ) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iREQ(iREQ), .iADDR(iADDR), .iFLUSH(iFLUSH),
        .oBUSY(oBUSY), .oDONE(oDONE), .oINSTR(oINSTR), .oERR(oERR),
        .oROM_CE(oROM_CE), .oROM_RD(oROM_RD), .oROM_ADDR(oROM_ADDR),
        .iROM_DATA(iROM_DATA), .iROM_VALID(iROM_VALID)
    );

    always #5 iCLK = ~iCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and settle before sampling or driving.
    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    initial begin
        // Reset values
        #2;
        check("rst_busy", 32'(oBUSY), 32'd0);
        check("rst_done", 32'(oDONE), 32'd0);
        check("rst_ce",   32'(oROM_CE), 32'd0);
        check("rst_rd",   32'(oROM_RD), 32'd0);
        check("rst_addr", 32'(oROM_ADDR), 32'd0);
        check("rst_instr", oINSTR, 32'h0);
        check("rst_err",  32'(oERR), 32'd0);
        #10;
        iRST_N = 1'b1;
        tick();

        // Basic fetch with a zero-wait ROM
        iREQ = 1'b1; iADDR = 8'h04;
        tick();
        check("t1_ce",   32'(oROM_CE), 32'd1);
        check("t1_rd",   32'(oROM_RD), 32'd1);
        check("t1_busy", 32'(oBUSY), 32'd1);
        check("t1_addr", 32'(oROM_ADDR), 32'h04);
        check("t1_nodone", 32'(oDONE), 32'd0);
        iREQ = 1'b0; iROM_VALID = 1'b1; iROM_DATA = 32'h00500093;
        tick();
        check("t1_done",  32'(oDONE), 32'd1);
        check("t1_instr", oINSTR, 32'h00500093);
        check("t1_ce_off", 32'(oROM_CE), 32'd0);
        check("t1_busy_off", 32'(oBUSY), 32'd0);
        check("t1_err",   32'(oERR), 32'd0);
        iROM_VALID = 1'b0;
        tick();
        check("t1_pulse", 32'(oDONE), 32'd0);
        check("t1_hold",  oINSTR, 32'h00500093);

        // ROM responds after 5 cycles of CE
        iREQ = 1'b1; iADDR = 8'h20;
        tick();
        iREQ = 1'b0;
        check("t2_ce0", 32'(oROM_CE), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t2_ce",   32'(oROM_CE), 32'd1);
            check("t2_addr", 32'(oROM_ADDR), 32'h20);
            check("t2_busy", 32'(oBUSY), 32'd1);
            check("t2_nodone", 32'(oDONE), 32'd0);
        end
        iROM_VALID = 1'b1; iROM_DATA = 32'h00A00113;
        tick();
        iROM_VALID = 1'b0;
        check("t2_done",  32'(oDONE), 32'd1);
        check("t2_instr", oINSTR, 32'h00A00113);
        tick();
        check("t2_pulse", 32'(oDONE), 32'd0);

        // A flush in IDLE overrides a request
        iREQ = 1'b1; iFLUSH = 1'b1; iADDR = 8'h24;
        tick();
        iREQ = 1'b0; iFLUSH = 1'b0;
        check("fl_idle_busy", 32'(oBUSY), 32'd0);
        check("fl_idle_ce",   32'(oROM_CE), 32'd0);

        // Timeout: 16 BUSRD cycles, then NOP and a sticky error
        iREQ = 1'b1; iADDR = 8'h30;
        tick();
        iREQ = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            check("t3_wait_done", 32'(oDONE), 32'd0);
            check("t3_wait_busy", 32'(oBUSY), 32'd1);
        end
        tick();
        check("t3_done",  32'(oDONE), 32'd1);
        check("t3_nop",   oINSTR, 32'h00000013);
        check("t3_err",   32'(oERR), 32'd1);
        check("t3_busy",  32'(oBUSY), 32'd0);
        tick();
        check("t3_pulse", 32'(oDONE), 32'd0);
        check("t3_sticky", 32'(oERR), 32'd1);

        // Flush on the same edge as valid data
        iREQ = 1'b1; iADDR = 8'h40;
        tick();
        iREQ = 1'b0; iFLUSH = 1'b1; iROM_VALID = 1'b1; iROM_DATA = 32'hFFFFFFFF;
        tick();
        iFLUSH = 1'b0; iROM_VALID = 1'b0;
        check("t4_nodone", 32'(oDONE), 32'd0);
        check("t4_instr",  oINSTR, 32'h00000013);
        check("t4_busy",   32'(oBUSY), 32'd0);
        check("t4_ce",     32'(oROM_CE), 32'd0);
        iREQ = 1'b1; iADDR = 8'h08;
        tick();
        iREQ = 1'b0;
        check("t4_addr", 32'(oROM_ADDR), 32'h08);
        check("t4_ce2",  32'(oROM_CE), 32'd1);
        iROM_VALID = 1'b1; iROM_DATA = 32'h00208033;
        tick();
        iROM_VALID = 1'b0;
        check("t4_done",  32'(oDONE), 32'd1);
        check("t4_instr2", oINSTR, 32'h00208033);
        tick();

        // Asynchronous reset for half a cycle in the middle of BUSRD
        iREQ = 1'b1; iADDR = 8'h50;
        tick();
        iREQ = 1'b0;
        tick();
        check("t5_pre_busy", 32'(oBUSY), 32'd1);
        #3;
        iRST_N = 1'b0;
        #1;
        check("t5_ce",   32'(oROM_CE), 32'd0);
        check("t5_rd",   32'(oROM_RD), 32'd0);
        check("t5_busy", 32'(oBUSY), 32'd0);
        check("t5_err",  32'(oERR), 32'd0);
        #4;
        iRST_N = 1'b1;
        iROM_VALID = 1'b1; iROM_DATA = 32'h12345678;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_nodone", 32'(oDONE), 32'd0);
            check("t5_idle",   32'(oBUSY), 32'd0);
        end
        iROM_VALID = 1'b0;
        check("t5_instr", oINSTR, 32'h0);
        check("t5_err2",  32'(oERR), 32'd0);

        // Fetch the same address twice back-to-back
        iREQ = 1'b1; iADDR = 8'h10;
        tick();
        iREQ = 1'b0; iROM_VALID = 1'b1; iROM_DATA = 32'h00C00193;
        tick();
        iROM_VALID = 1'b0;
        check("t6_done1",  32'(oDONE), 32'd1);
        check("t6_instr1", oINSTR, 32'h00C00193);
        iREQ = 1'b1; iADDR = 8'h10;
        tick();
        iREQ = 1'b0;
`ifdef FETCH_HIT_EN
        check("t6_hit_ce",    32'(oROM_CE), 32'd0);
        check("t6_hit_done",  32'(oDONE), 32'd1);
        check("t6_hit_instr", oINSTR, 32'h00C00193);
        tick();
        check("t6_hit_pulse", 32'(oDONE), 32'd0);
`else
        check("t6_miss_ce",   32'(oROM_CE), 32'd1);
        check("t6_miss_done", 32'(oDONE), 32'd0);
        iROM_VALID = 1'b1; iROM_DATA = 32'h00C00193;
        tick();
        iROM_VALID = 1'b0;
        check("t6_done2",  32'(oDONE), 32'd1);
        check("t6_instr2", oINSTR, 32'h00C00193);
`endif
        tick();

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
